// File: rtl/pip_pkg.sv
// pip_pkg: shared definitions for the execute-to-memory pipeline slice.
//   - PIP_* width constants: default field widths of the EX/MEM payload
//   - skid_state_e: occupancy state of the elastic EX/MEM register
//   - exmem_t: the EX/MEM payload carried through the register
//   - state_occ(): maps a state to its entry count (0..2)
package pip_pkg;

  localparam int PIP_PC_WIDTH         = 32;
  localparam int PIP_DATA_WIDTH       = 32;
  localparam int PIP_REG_ADDR_WIDTH   = 5;
  localparam int PIP_RESULT_SRC_WIDTH = 2;

  // Encoding doubles as the entry count; 2'd3 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic                            reg_write;
    logic [PIP_RESULT_SRC_WIDTH-1:0] result_src;
    logic                            mem_write;
    logic [PIP_DATA_WIDTH-1:0]       alu_result;
    logic [PIP_DATA_WIDTH-1:0]       write_data;
    logic [PIP_REG_ADDR_WIDTH-1:0]   rd;
    logic [PIP_PC_WIDTH-1:0]         pc_plus4;
  } exmem_t;

  function automatic logic [1:0] state_occ(skid_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pip_skid_ctrl.sv
// pip_skid_ctrl: occupancy state machine of the 2-entry EX/MEM skid register.
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           squash everything this cycle (highest priority)
//   valid_i           upstream offers an entry
//   ready_o           upstream may hand over an entry (registered state only)
//   valid_o           main entry valid
//   ready_i           downstream consumes the main entry
//   load_main_o       main payload register loads this cycle
//   main_from_skid_o  main loads from skid (else from the input)
//   load_skid_o       skid payload register loads from the input
//   state_o           current state (debug visibility)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and ready_o never depends on
// ready_i combinationally. A flush cancels any transfer of that cycle.
module pip_skid_ctrl
  import pip_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        load_main_o,
  output logic        main_from_skid_o,
  output logic        load_skid_o,
  output skid_state_e state_o
);

  skid_state_e state_q, state_d;
  logic        in_fire, out_fire;

  assign ready_o  = (state_q != ST_TWO);
  assign valid_o  = (state_q != ST_EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;
  assign state_o  = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    load_main_o      = 1'b0;
    main_from_skid_o = 1'b0;
    load_skid_o      = 1'b0;
    if (flush_i) begin
      // Payload registers keep stale data; valid bits drop to zero.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            load_main_o = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_o = 1'b1;
          end else if (in_fire) begin
            state_d     = ST_TWO;
            load_skid_o = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d          = ST_ONE;
            load_main_o      = 1'b1;
            main_from_skid_o = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pip_skid_em.sv
// pip_skid_em: elastic EX/MEM pipeline register with a 2-entry skid buffer.
//   Execute side : ValidE_i / ReadyE_o handshake plus the E payload fields.
//   Memory side  : ValidM_o / ReadyM_i handshake plus the M payload fields
//                  (main entry), OccM_o = entries held (0..2).
//   flush_i      : synchronous squash of held and incoming entries.
//   clk_i, rst_ni: clock, asynchronous active-low reset.
// The width parameters must equal the pip_pkg PIP_* constants, since the
// stored payload uses the package struct.
module pip_skid_em
  import pip_pkg::*;
#(
  parameter int PC_WIDTH               = PIP_PC_WIDTH,
  parameter int DATA_WIDTH             = PIP_DATA_WIDTH,
  parameter int REGISTER_ADDRESS_WIDTH = PIP_REG_ADDR_WIDTH,
  parameter int RESULT_SRC_WIDTH       = PIP_RESULT_SRC_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              ValidE_i,
  output logic                              ReadyE_o,
  input  logic                              RegWriteE_i,
  input  logic [RESULT_SRC_WIDTH-1:0]       ResultSrcE_i,
  input  logic                              MemWriteE_i,
  input  logic [DATA_WIDTH-1:0]             ALUResultE_i,
  input  logic [DATA_WIDTH-1:0]             WriteDataE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [PC_WIDTH-1:0]               PCPlus4E_i,
  output logic                              ValidM_o,
  input  logic                              ReadyM_i,
  output logic                              RegWriteM_o,
  output logic [RESULT_SRC_WIDTH-1:0]       ResultSrcM_o,
  output logic                              MemWriteM_o,
  output logic [DATA_WIDTH-1:0]             ALUResultM_o,
  output logic [DATA_WIDTH-1:0]             WriteDataM_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_o,
  output logic [PC_WIDTH-1:0]               PCPlus4M_o,
  output logic [1:0]                        OccM_o
);

  exmem_t      in_pl, main_q, skid_q;
  logic        load_main, main_from_skid, load_skid;
  skid_state_e ctrl_state;

  assign in_pl.reg_write  = RegWriteE_i;
  assign in_pl.result_src = ResultSrcE_i;
  assign in_pl.mem_write  = MemWriteE_i;
  assign in_pl.alu_result = ALUResultE_i;
  assign in_pl.write_data = WriteDataE_i;
  assign in_pl.rd         = RdE_i;
  assign in_pl.pc_plus4   = PCPlus4E_i;

  pip_skid_ctrl u_ctrl (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .valid_i          (ValidE_i),
    .ready_o          (ReadyE_o),
    .valid_o          (ValidM_o),
    .ready_i          (ReadyM_i),
    .load_main_o      (load_main),
    .main_from_skid_o (main_from_skid),
    .load_skid_o      (load_skid),
    .state_o          (ctrl_state)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_pl;
      if (load_skid) skid_q <= in_pl;
    end
  end

  assign OccM_o = state_occ(ctrl_state);

  // Only the side-effecting enables are qualified; the rest of the payload
  // shows the last stored main entry while invalid.
  assign RegWriteM_o  = main_q.reg_write & ValidM_o;
  assign MemWriteM_o  = main_q.mem_write & ValidM_o;
  assign ResultSrcM_o = main_q.result_src;
  assign ALUResultM_o = main_q.alu_result;
  assign WriteDataM_o = main_q.write_data;
  assign RdM_o        = main_q.rd;
  assign PCPlus4M_o   = main_q.pc_plus4;

endmodule

// File: tb/tb_pip_skid_em.sv
module tb_pip_skid_em;

  localparam int PW = 1 + 2 + 1 + 32 + 32 + 5 + 32;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        ValidE_i;
  logic        ReadyE_o;
  logic        RegWriteE_i;
  logic [1:0]  ResultSrcE_i;
  logic        MemWriteE_i;
  logic [31:0] ALUResultE_i;
  logic [31:0] WriteDataE_i;
  logic [4:0]  RdE_i;
  logic [31:0] PCPlus4E_i;
  logic        ValidM_o;
  logic        ReadyM_i;
  logic        RegWriteM_o;
  logic [1:0]  ResultSrcM_o;
  logic        MemWriteM_o;
  logic [31:0] ALUResultM_o;
  logic [31:0] WriteDataM_o;
  logic [4:0]  RdM_o;
  logic [31:0] PCPlus4M_o;
  logic [1:0]  OccM_o;

  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  pip_skid_em dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .ValidE_i     (ValidE_i),
    .ReadyE_o     (ReadyE_o),
    .RegWriteE_i  (RegWriteE_i),
    .ResultSrcE_i (ResultSrcE_i),
    .MemWriteE_i  (MemWriteE_i),
    .ALUResultE_i (ALUResultE_i),
    .WriteDataE_i (WriteDataE_i),
    .RdE_i        (RdE_i),
    .PCPlus4E_i   (PCPlus4E_i),
    .ValidM_o     (ValidM_o),
    .ReadyM_i     (ReadyM_i),
    .RegWriteM_o  (RegWriteM_o),
    .ResultSrcM_o (ResultSrcM_o),
    .MemWriteM_o  (MemWriteM_o),
    .ALUResultM_o (ALUResultM_o),
    .WriteDataM_o (WriteDataM_o),
    .RdM_o        (RdM_o),
    .PCPlus4M_o   (PCPlus4M_o),
    .OccM_o       (OccM_o)
  );

  // Clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] make_pl(input logic [31:0] alu, input logic mw);
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    rw = 1'($urandom_range(1));
    rs = 2'($urandom_range(3));
    wd = $urandom;
    rd = 5'($urandom_range(31));
    pc = $urandom;
    return {rw, rs, mw, alu, wd, rd, pc};
  endfunction

  function automatic logic [PW-1:0] head_obs();
    return {RegWriteM_o, ResultSrcM_o, MemWriteM_o, ALUResultM_o,
            WriteDataM_o, RdM_o, PCPlus4M_o};
  endfunction

  task automatic drive_pl(input logic [PW-1:0] p);
    {RegWriteE_i, ResultSrcE_i, MemWriteE_i, ALUResultE_i,
     WriteDataE_i, RdE_i, PCPlus4E_i} = p;
  endtask

  // Driver: called at a negedge. Applies inputs, checks the outputs against
  // the expected queue (its size is the expected occupancy), updates the
  // scoreboard for the coming rising edge, then advances one cycle.
  task automatic step(input logic ve, input logic rm, input logic fl, input logic [PW-1:0] p);
    int  occ;
    logic in_f, out_f;
    ValidE_i = ve;
    ReadyM_i = rm;
    flush_i  = fl;
    drive_pl(p);
    occ = exp_q.size();
    #1;
    chk("valid_m", 128'(ValidM_o), 128'(occ > 0));
    chk("ready_e", 128'(ReadyE_o), 128'(occ != 2));
    chk("occ_m", 128'(OccM_o), 128'(occ));
    if (occ > 0) begin
      chk("head_payload", 128'(head_obs()), 128'(exp_q[0]));
    end else begin
      chk("regwrite_gated", 128'(RegWriteM_o), 128'd0);
      chk("memwrite_gated", 128'(MemWriteM_o), 128'd0);
    end
    out_f = (occ > 0) && rm && !fl;
    in_f  = ve && (occ != 2) && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back(p);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, make_pl(32'hdead_0000, 1'b1));
  endtask

  initial begin
    rst_ni = 1'b0;
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      ValidE_i = 1'($urandom_range(1));
      ReadyM_i = 1'($urandom_range(1));
      flush_i  = 1'($urandom_range(1));
      drive_pl(make_pl($urandom, 1'($urandom_range(1))));
      @(negedge clk_i);
      chk("rst_valid_m", 128'(ValidM_o), 128'd0);
      chk("rst_ready_e", 128'(ReadyE_o), 128'd1);
      chk("rst_occ_m", 128'(OccM_o), 128'd0);
      chk("rst_regwrite", 128'(RegWriteM_o), 128'd0);
      chk("rst_memwrite", 128'(MemWriteM_o), 128'd0);
      chk("rst_alu", 128'(ALUResultM_o), 128'd0);
      chk("rst_pc4", 128'(PCPlus4M_o), 128'd0);
    end
    ValidE_i = 1'b0;
    flush_i  = 1'b0;
    rst_ni   = 1'b1;

    // Streaming at full rate
    step(1'b1, 1'b1, 1'b0, make_pl(32'h10, 1'b0));
    step(1'b1, 1'b1, 1'b0, make_pl(32'h14, 1'b0));
    step(1'b1, 1'b1, 1'b0, make_pl(32'h18, 1'b0));
    idle(2);

    // Backpressure: 0xA held, 0xB skids, 0xC refused until space frees
    step(1'b1, 1'b0, 1'b0, make_pl(32'hA, 1'b1));
    step(1'b1, 1'b0, 1'b0, make_pl(32'hB, 1'b1));
    step(1'b1, 1'b0, 1'b0, make_pl(32'hC, 1'b1));
    step(1'b1, 1'b0, 1'b0, make_pl(32'hC, 1'b1));
    chk("bp_alu_held", 128'(ALUResultM_o), 128'hA);
    step(1'b1, 1'b1, 1'b0, make_pl(32'hC, 1'b1));
    step(1'b1, 1'b1, 1'b0, make_pl(32'hC, 1'b1));
    idle(2);

    // Flush while TWO with store entries; the offer in the flush cycle is lost
    step(1'b1, 1'b0, 1'b0, make_pl(32'h100, 1'b1));
    step(1'b1, 1'b0, 1'b0, make_pl(32'h104, 1'b1));
    step(1'b1, 1'b0, 1'b1, make_pl(32'h108, 1'b1));
    chk("flush_memwrite", 128'(MemWriteM_o), 128'd0);
    idle(2);

    // Simultaneous in/out in ONE replaces main without using skid
    step(1'b1, 1'b0, 1'b0, make_pl(32'h200, 1'b0));
    step(1'b1, 1'b1, 1'b0, make_pl(32'h204, 1'b0));
    chk("swap_occ", 128'(OccM_o), 128'd1);
    chk("swap_alu", 128'(ALUResultM_o), 128'h204);
    idle(2);

    // Asynchronous reset pulse between clock edges during a stall
    step(1'b1, 1'b0, 1'b0, make_pl(32'h300, 1'b1));
    step(1'b1, 1'b0, 1'b0, make_pl(32'h304, 1'b1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid_m", 128'(ValidM_o), 128'd0);
    chk("arst_ready_e", 128'(ReadyE_o), 128'd1);
    chk("arst_occ_m", 128'(OccM_o), 128'd0);
    chk("arst_memwrite", 128'(MemWriteM_o), 128'd0);
    chk("arst_alu", 128'(ALUResultM_o), 128'd0);
    exp_q.delete();
    ValidE_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 1'b1, 1'b0, make_pl(32'h400, 1'b0));
    step(1'b1, 1'b1, 1'b0, make_pl(32'h404, 1'b1));
    idle(2);

    // Random traffic with occasional flushes
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(9) == 0), make_pl($urandom, 1'($urandom_range(1))));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
